// File: rtl/autoc_lag_corr.sv
// autoc_lag_corr: x[n]*conj(x[n-lag]) with a 2^WIN_LOG2 moving sum, 4-cycle pipeline.
// Define AUTOC_POWER_EN to add out_pwr, the windowed power of the delayed sample.
module autoc_lag_corr #(
  parameter int SW = 16,
  parameter int MAX_LAG_LOG2 = 6,
  parameter int WIN_LOG2 = 4,
  localparam int ACC_W = 2*SW+1+WIN_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [MAX_LAG_LOG2-1:0] lag,
  input  logic [2*SW-1:0]         sample_in,
  input  logic                    strobe_in,
  output logic                    ddc_enable,
  output logic [ACC_W-1:0]        out_i,
  output logic [ACC_W-1:0]        out_q,
  output logic                    out_strobe,
  output logic                    out_valid
`ifdef AUTOC_POWER_EN
  , output logic [ACC_W-1:0]      out_pwr
`endif
);
  localparam int D   = 1 << MAX_LAG_LOG2;
  localparam int W   = 1 << WIN_LOG2;
  localparam int PW  = 2*SW;
  localparam int S1W = 2*SW+1;
  localparam int CW  = $clog2(D+W+1);
`ifdef AUTOC_POWER_EN
  localparam int EW  = 3*S1W;
`else
  localparam int EW  = 2*S1W;
`endif
  logic [MAX_LAG_LOG2-1:0] lag_q, wr_ptr_q;
  logic [CW-1:0]           cnt_q;
  logic [WIN_LOG2-1:0]     wptr_q;
  logic [WIN_LOG2:0]       pcnt_q;
  logic [2*SW-1:0]         mem [D];
  logic [EW-1:0]           wmem [W];
  logic                    s1_q, s2_q, s3_q, v1_q, v2_q, v3_q;
  logic signed [PW-1:0]    xi1_q, xq1_q, di1_q, dq1_q;
  logic signed [PW-1:0]    ii2_q, qq2_q, qi2_q, iq2_q;
  logic signed [S1W-1:0]   re3_q, im3_q, old_re, old_im;
  logic                    take, vld;
  logic [2*SW-1:0]         dly;
  logic [EW-1:0]           wnew, old;
`ifdef AUTOC_POWER_EN
  logic signed [PW-1:0]    pi2_q, pq2_q;
  logic [S1W-1:0]          pw3_q, old_pw;
`endif
  assign take = strobe_in && !rst && !clear;
  // history younger than the lag reads as zero, so neither RAM needs a reset
  always_comb begin
    dly = (lag_q == '0) ? sample_in : (cnt_q < CW'(lag_q)) ? '0 : mem[wr_ptr_q - lag_q];
    vld = cnt_q >= CW'(lag_q) + CW'(W-1);
    old = pcnt_q[WIN_LOG2] ? wmem[wptr_q] : '0;
    old_re = old[S1W-1:0];
    old_im = old[2*S1W-1:S1W];
`ifdef AUTOC_POWER_EN
    old_pw = old[3*S1W-1:2*S1W];
    wnew = {pw3_q, im3_q, re3_q};
`else
    wnew = {im3_q, re3_q};
`endif
  end
  always_ff @(posedge clk) begin
    if (take) mem[wr_ptr_q] <= sample_in;
    if (s3_q && !rst && !clear) wmem[wptr_q] <= wnew;
    xi1_q <= PW'($signed(sample_in[2*SW-1:SW]));
    xq1_q <= PW'($signed(sample_in[SW-1:0]));
    di1_q <= PW'($signed(dly[2*SW-1:SW]));
    dq1_q <= PW'($signed(dly[SW-1:0]));
    ii2_q <= xi1_q * di1_q;
    qq2_q <= xq1_q * dq1_q;
    qi2_q <= xq1_q * di1_q;
    iq2_q <= xi1_q * dq1_q;
    re3_q <= S1W'(ii2_q) + S1W'(qq2_q);
    im3_q <= S1W'(qi2_q) - S1W'(iq2_q);
`ifdef AUTOC_POWER_EN
    pi2_q <= di1_q * di1_q;
    pq2_q <= dq1_q * dq1_q;
    pw3_q <= S1W'(pi2_q) + S1W'(pq2_q);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ddc_enable <= !rst;
      lag_q      <= lag;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      pcnt_q     <= '0;
      {s1_q, s2_q, s3_q, v1_q, v2_q, v3_q} <= '0;
      out_i      <= '0;
      out_q      <= '0;
      out_strobe <= 1'b0;
      out_valid  <= 1'b0;
`ifdef AUTOC_POWER_EN
      out_pwr    <= '0;
`endif
    end else begin
      ddc_enable <= 1'b1;
      s1_q       <= strobe_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      v1_q       <= vld;
      v2_q       <= v1_q;
      v3_q       <= v2_q;
      out_strobe <= s3_q;
      if (strobe_in) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        cnt_q    <= (cnt_q == CW'(D+W)) ? cnt_q : cnt_q + CW'(1);
      end
      if (s3_q) begin
        wptr_q    <= wptr_q + 1'b1;
        pcnt_q    <= pcnt_q[WIN_LOG2] ? pcnt_q : pcnt_q + 1'b1;
        out_i     <= out_i + ACC_W'(re3_q) - ACC_W'(old_re);
        out_q     <= out_q + ACC_W'(im3_q) - ACC_W'(old_im);
        out_valid <= out_valid | v3_q;
`ifdef AUTOC_POWER_EN
        out_pwr   <= out_pwr + ACC_W'(pw3_q) - ACC_W'(old_pw);
`endif
      end
    end
  end
endmodule

// File: doc/autoc_lag_corr.md
Name: autoc_lag_corr

Overview:
- Parametrised delay-and-correlate autocorrelator for the RX DDC output.
- Takes strobed {I,Q} samples and forms the product x[n]*conj(x[n-D]) at a run-time lag D.
- Keeps a moving sum of the last 2^WIN_LOG2 products and emits the complex result with a valid flag.
- Sits after the DDC chain and feeds packet/preamble detection logic.

Parameters:
- SW, 16, signed width of each I/Q component; the input sample is {I[2SW-1:SW], Q[SW-1:0]}.
- MAX_LAG_LOG2, 6, delay-line depth is 2^MAX_LAG_LOG2, so lag range is 0..63.
- WIN_LOG2, 4, moving-sum window length is 2^WIN_LOG2 products.
- ACC_W, 2*SW+1+WIN_LOG2, output width; derived, must not be overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous restart: flushes history and re-latches lag; configuration is otherwise kept.
- lag  in  MAX_LAG_LOG2  correlation lag D; latched only on rst or clear.
- sample_in  in  2*SW  {I,Q} sample, two's complement.
- strobe_in  in  1  high for one cycle per valid sample; may be high on every cycle.
- ddc_enable  out  1  enables the DDC chain.
- out_i  out  ACC_W  real part of the moving sum, signed.
- out_q  out  ACC_W  imaginary part of the moving sum, signed.
- out_strobe  out  1  one pulse per input strobe.
- out_valid  out  1  window is fully populated with real data.

Behaviour:
- Reset (rst=1): all outputs are 0, ddc_enable=0, lag_r=lag, counters are 0, pipeline strobes are cleared. ddc_enable=1 from the first cycle after rst deasserts.
- clear: same effect as rst on counters, accumulators, outputs and lag_r. ddc_enable stays 1. A strobe_in in the same cycle as clear or rst is dropped.
- Delay line: circular RAM, depth 2^MAX_LAG_LOG2. wr_ptr increments on each strobe and wraps modulo the depth. Delayed read address = wr_ptr - lag_r (mod depth).
  - The delayed sample is forced to 0 while sample count < lag_r, so the RAM needs no reset.
  - lag_r=0 returns the current sample, giving |x|^2.
- Product, full precision:
  - re = I*Id + Q*Qd
  - im = Q*Id - I*Qd
  - Each partial product is 2SW bits; each sum is 2SW+1 bits, sign-extended.
- Window: product history RAM, depth 2^WIN_LOG2, stores the (re, im) pairs. On each product:
  - acc += new - oldest.
  - The oldest entry is forced to 0 while product count < 2^WIN_LOG2.
  - ACC_W bits are enough, so no overflow or saturation logic is needed.
- Pipeline: fixed latency of 4 clk from strobe_in to out_strobe, fully pipelined, independent of strobe spacing.
  - Stage 1: RAM write and delayed read.
  - Stage 2: multiply.
  - Stage 3: add/sub.
  - Stage 4: accumulate and register outputs.
- Outputs: out_i and out_q update only on the out_strobe cycle and hold otherwise.
- Sample counter: saturates at 2^MAX_LAG_LOG2 + 2^WIN_LOG2.
- out_valid:
  - Rises together with the out_strobe of input sample number lag_r + 2^WIN_LOG2 (1-based).
  - Stays high until rst or clear.
- A change on the lag port without rst or clear has no effect.
- Counter and pointer wrap-around is seamless; no bubbles are inserted at wrap.
- Reset mid-operation: in-flight pipeline samples are discarded; no out_strobe is issued for them.

Optional Feature:
- Macro: AUTOC_POWER_EN.
- Defined:
  - Adds output port out_pwr (ACC_W bits, unsigned).
  - out_pwr is the moving sum over the same window of I^2+Q^2 of the delayed sample.
  - It shares the window RAM (widened) and has the same latency, strobe and valid behaviour.
  - Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Constant input (1000,0), lag=4, defaults → out_valid rises on the 20th out_strobe; out_i=16000000, out_q=0 from then on; outputs before that ramp by 1000000 per strobe starting at strobe 5.
- Phasor sequence (A,0),(0,A),(-A,0),(0,-A) repeating with A=1000, lag=1 → after valid: out_i=0, out_q=16000000.
- Input (-32768,-32768), lag=0, back-to-back strobes → after 16 strobes: out_i=34359738368 (2^35), out_q=0, no wrap; out_strobe is exactly 4 cycles after each strobe_in.
- The same random 200-sample stream sent back-to-back and again with random gaps of 0-5 cycles → identical out_i/out_q sequences; out_strobe count = 200 in both runs.
- lag changed from 4 to 9 mid-stream without clear → results still match lag 4; then pulse clear → out_valid drops, outputs go to 0, and the next valid appears on the 25th subsequent strobe with lag 9 results.
- rst asserted for 1 cycle with 3 samples in the pipeline → no further out_strobe; outputs are 0, ddc_enable=0 during rst and 1 on the next cycle.
